chess_board_state: RTL and testbench

//   Sequential owner of the game board: holds a ROWS x COLS array of square codes, loads the standard start

---
 rtl/chess_board_state.sv | 199 +++++++++++++++++++
 tb/tb_chess_board_state.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/chess_board_state.sv
// Board-state owner: holds the square codes, reloads the start position, and applies
// one pre-checked move per request (IDLE -> CHECK -> COMMIT -> RESP).
module chess_board_state #(
    parameter int ROWS  = 8,
    parameter int COLS  = 8,
    parameter int SQ_W  = 5,
    parameter int CNT_W = 10,
    parameter int RW    = (ROWS > 1) ? $clog2(ROWS) : 1,
    parameter int CW    = (COLS > 1) ? $clog2(COLS) : 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             init,
    input  logic             mv_valid,
    output logic             mv_ready,
    input  logic [RW-1:0]    mv_from_r,
    input  logic [CW-1:0]    mv_from_c,
    input  logic [RW-1:0]    mv_to_r,
    input  logic [CW-1:0]    mv_to_c,
    input  logic [2:0]       mv_promo,
    output logic             rsp_valid,
    output logic [2:0]       rsp_status,
    output logic [SQ_W-1:0]  rsp_capture,
    output logic             side_to_move,
    output logic [CNT_W-1:0] move_count,
    input  logic [RW-1:0]    rd_r,
    input  logic [CW-1:0]    rd_c,
    output logic [SQ_W-1:0]  rd_sq
);
    typedef logic [ROWS-1:0][COLS-1:0][SQ_W-1:0] board_t;
    typedef enum logic [1:0] {S_IDLE, S_CHECK, S_COMMIT, S_RESP} state_t;

    localparam logic [RW:0] ROWS_L  = (RW+1)'(ROWS);
    localparam logic [RW:0] ROWS_M1 = (RW+1)'(ROWS - 1);
    localparam logic [CW:0] COLS_L  = (CW+1)'(COLS);

    function automatic board_t start_board();
        board_t     b;
        logic [2:0] t;
        b = '0;
        for (int r = 0; r < ROWS; r++) begin
            for (int c = 0; c < COLS; c++) begin
                case (c % 8)
                    0, 7:    t = 3'b100;
                    1, 6:    t = 3'b010;
                    2, 5:    t = 3'b011;
                    3:       t = 3'b101;
                    default: t = 3'b110;
                endcase
                if (r == 1 || r == ROWS - 2) t = 3'b001;
                if (r <= 1 || r >= ROWS - 2) begin
                    b[r][c][4:2] = t;
                    b[r][c][1]   = (r <= 1);
                    b[r][c][0]   = 1'b1;
                end
            end
        end
        return b;
    endfunction

    localparam board_t START = start_board();

    state_t            r_state, w_next;
    board_t            r_board;
    logic              r_side;
    logic [CNT_W-1:0]  r_cnt;
    logic [RW-1:0]     r_from_r, r_to_r;
    logic [CW-1:0]     r_from_c, r_to_c;
    logic [2:0]        r_promo;
    logic [SQ_W-1:0]   r_src_sq, r_dst_sq;
    logic [2:0]        r_status;
    logic              r_rsp_valid;
    logic [2:0]        r_rsp_status;
    logic [SQ_W-1:0]   r_rsp_capture;

    logic              w_accept, w_check, w_commit, w_resp;
    logic              w_from_in, w_to_in, w_rd_in;
    logic [SQ_W-1:0]   w_src, w_dst, w_moved;
    logic [2:0]        w_status, w_ptype;
    logic              w_promo_hit;

    // FSM: state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset)     r_state <= S_IDLE;
        else if (init) r_state <= S_IDLE;
        else           r_state <= w_next;
    end

    // FSM: next state
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:   if (w_accept) w_next = S_CHECK;
            S_CHECK:  w_next = S_COMMIT;
            S_COMMIT: w_next = S_RESP;
            default:  w_next = S_IDLE;
        endcase
    end

    // FSM: outputs / strobes
    always_comb begin
        mv_ready = (r_state == S_IDLE) && !init;
        w_accept = mv_valid && mv_ready;
        w_check  = (r_state == S_CHECK);
        w_commit = (r_state == S_COMMIT) && (r_status == 3'd0);
        w_resp   = (r_state == S_RESP);
    end

    // Squares are only indexed when the coordinate is on the board.
    always_comb begin
        w_from_in = ({1'b0, r_from_r} < ROWS_L) && ({1'b0, r_from_c} < COLS_L);
        w_to_in   = ({1'b0, r_to_r}   < ROWS_L) && ({1'b0, r_to_c}   < COLS_L);
        w_src     = w_from_in ? r_board[r_from_r][r_from_c] : '0;
        w_dst     = w_to_in   ? r_board[r_to_r][r_to_c]     : '0;
        if (!w_from_in || !w_to_in)                         w_status = 3'd4;
        else if (r_from_r == r_to_r && r_from_c == r_to_c)  w_status = 3'd5;
        else if (!w_src[0])                                 w_status = 3'd1;
        else if (w_src[1] != r_side)                        w_status = 3'd2;
        else if (w_dst[0] && (w_dst[1] == w_src[1]))        w_status = 3'd3;
        else                                                w_status = 3'd0;
    end

    always_comb begin
        w_promo_hit = (r_src_sq[4:2] == 3'b001) &&
                      ((!r_src_sq[1] && r_to_r == '0) ||
                       ( r_src_sq[1] && {1'b0, r_to_r} == ROWS_M1));
        w_ptype     = (mv_promo_ok(r_promo)) ? r_promo : 3'b101;
        w_moved     = r_src_sq;
        if (w_promo_hit) w_moved[4:2] = w_ptype;
    end

    function automatic logic mv_promo_ok(input logic [2:0] p);
        return (p >= 3'b010) && (p <= 3'b101);
    endfunction

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_board       <= START;
            r_side        <= 1'b0;
            r_cnt         <= '0;
            r_from_r      <= '0;
            r_from_c      <= '0;
            r_to_r        <= '0;
            r_to_c        <= '0;
            r_promo       <= '0;
            r_src_sq      <= '0;
            r_dst_sq      <= '0;
            r_status      <= '0;
            r_rsp_valid   <= 1'b0;
            r_rsp_status  <= '0;
            r_rsp_capture <= '0;
        end else if (init) begin
            r_board       <= START;
            r_side        <= 1'b0;
            r_cnt         <= '0;
            r_status      <= '0;
            r_rsp_valid   <= 1'b0;
            r_rsp_status  <= '0;
            r_rsp_capture <= '0;
        end else begin
            r_rsp_valid <= 1'b0;
            if (w_accept) begin
                r_from_r <= mv_from_r;
                r_from_c <= mv_from_c;
                r_to_r   <= mv_to_r;
                r_to_c   <= mv_to_c;
                r_promo  <= mv_promo;
            end
            if (w_check) begin
                r_src_sq <= w_src;
                r_dst_sq <= w_dst;
                r_status <= w_status;
            end
            if (w_commit) begin
                r_board[r_to_r][r_to_c]     <= w_moved;
                r_board[r_from_r][r_from_c] <= '0;
                r_side                      <= ~r_side;
                if (r_cnt != '1) r_cnt <= r_cnt + 1'b1;
            end
            if (w_resp) begin
                r_rsp_valid   <= 1'b1;
                r_rsp_status  <= r_status;
                r_rsp_capture <= (r_status == 3'd0) ? r_dst_sq : '0;
            end
        end
    end

    always_comb begin
        w_rd_in = ({1'b0, rd_r} < ROWS_L) && ({1'b0, rd_c} < COLS_L);
        rd_sq   = w_rd_in ? r_board[rd_r][rd_c] : '0;
    end

    assign rsp_valid    = r_rsp_valid;
    assign rsp_status   = r_rsp_status;
    assign rsp_capture  = r_rsp_capture;
    assign side_to_move = r_side;
    assign move_count   = r_cnt;

endmodule

// File: tb/tb_chess_board_state.sv
// Directed bench for chess_board_state: an 8x8 board plus a 10x6 board with a 2-bit move counter.
module tb_chess_board_state;
    logic       clk = 1'b0;
    logic       reset, init;
    logic       mv_valid, mv_ready;
    logic [2:0] mv_from_r, mv_from_c, mv_to_r, mv_to_c, mv_promo;
    logic       rsp_valid;
    logic [2:0] rsp_status;
    logic [4:0] rsp_capture;
    logic       side_to_move;
    logic [9:0] move_count;
    logic [2:0] rd_r, rd_c;
    logic [4:0] rd_sq;

    logic       b_init, b_valid, b_ready, b_rsp_valid, b_side;
    logic [3:0] b_from_r, b_to_r, b_rd_r;
    logic [2:0] b_from_c, b_to_c, b_promo, b_rd_c, b_status;
    logic [4:0] b_capture, b_rd_sq;
    logic [1:0] b_count;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    chess_board_state u_dut (
        .clk(clk), .reset(reset), .init(init), .mv_valid(mv_valid), .mv_ready(mv_ready),
        .mv_from_r(mv_from_r), .mv_from_c(mv_from_c), .mv_to_r(mv_to_r), .mv_to_c(mv_to_c),
        .mv_promo(mv_promo), .rsp_valid(rsp_valid), .rsp_status(rsp_status),
        .rsp_capture(rsp_capture), .side_to_move(side_to_move), .move_count(move_count),
        .rd_r(rd_r), .rd_c(rd_c), .rd_sq(rd_sq)
    );

    chess_board_state #(.ROWS(10), .COLS(6), .CNT_W(2)) u_big (
        .clk(clk), .reset(reset), .init(b_init), .mv_valid(b_valid), .mv_ready(b_ready),
        .mv_from_r(b_from_r), .mv_from_c(b_from_c), .mv_to_r(b_to_r), .mv_to_c(b_to_c),
        .mv_promo(b_promo), .rsp_valid(b_rsp_valid), .rsp_status(b_status),
        .rsp_capture(b_capture), .side_to_move(b_side), .move_count(b_count),
        .rd_r(b_rd_r), .rd_c(b_rd_c), .rd_sq(b_rd_sq)
    );

    // Start-position model built from the back-rank letters
    function automatic logic [4:0] exp_start(input int r, input int c, input int rows);
        string      bk;
        logic [2:0] t;
        bk = "RNBQKBNR";
        case (bk[c % 8])
            "R":     t = 3'd4;
            "N":     t = 3'd2;
            "B":     t = 3'd3;
            "Q":     t = 3'd5;
            default: t = 3'd6;
        endcase
        if (r == 1 || r == rows - 2) return {3'd1, 1'b0, 1'b1} | ((r == 1) ? 5'b00010 : 5'b0);
        if (r == 0)        return {t, 2'b11};
        if (r == rows - 1) return {t, 2'b01};
        return 5'b0;
    endfunction

    task automatic send(input logic [2:0] fr, fc, tr, tc, pr,
                        output int lat, output logic [2:0] st, output logic [4:0] cap);
        @(negedge clk);
        mv_from_r = fr; mv_from_c = fc; mv_to_r = tr; mv_to_c = tc; mv_promo = pr;
        mv_valid = 1'b1;
        @(posedge clk); #1;
        mv_valid = 1'b0;
        lat = 0;
        while (rsp_valid !== 1'b1 && lat < 10) begin
            @(posedge clk); #1;
            lat++;
        end
        st = rsp_status; cap = rsp_capture;
    endtask

    task automatic send_b(input logic [3:0] fr, input logic [2:0] fc, input logic [3:0] tr,
                          input logic [2:0] tc, output int lat, output logic [2:0] st);
        @(negedge clk);
        b_from_r = fr; b_from_c = fc; b_to_r = tr; b_to_c = tc; b_promo = 3'd0;
        b_valid = 1'b1;
        @(posedge clk); #1;
        b_valid = 1'b0;
        lat = 0;
        while (b_rsp_valid !== 1'b1 && lat < 10) begin
            @(posedge clk); #1;
            lat++;
        end
        st = b_status;
    endtask

    task automatic rd(input logic [2:0] r, c, output logic [4:0] q);
        rd_r = r; rd_c = c; #1; q = rd_sq;
    endtask

    task automatic test_reset();
        logic [4:0] q;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        n_tests++; if (rsp_valid !== 1'b0 || side_to_move !== 1'b0 || move_count !== 10'd0) begin
            n_fail++; $display("FAIL reset_regs: got v=%b s=%b c=%0d want 0 0 0", rsp_valid, side_to_move, move_count); end
        @(negedge clk); reset = 1'b0; #1;
        n_tests++; if (mv_ready !== 1'b1 || rsp_status !== 3'd0 || rsp_capture !== 5'd0) begin
            n_fail++; $display("FAIL reset_ready: got rdy=%b st=%0d cap=%b want 1 0 0", mv_ready, rsp_status, rsp_capture); end
        for (int r = 0; r < 8; r++)
            for (int c = 0; c < 8; c++) begin
                rd(3'(r), 3'(c), q);
                n_tests++; if (q !== exp_start(r, c, 8)) begin
                    n_fail++; $display("FAIL reset_sq[%0d][%0d]: got %b want %b", r, c, q, exp_start(r, c, 8)); end
            end
        rd(3'd0, 3'd4, q);
        n_tests++; if (q !== 5'b11011) begin n_fail++; $display("FAIL black_king: got %b want 11011", q); end
        rd(3'd7, 3'd3, q);
        n_tests++; if (q !== 5'b10101) begin n_fail++; $display("FAIL white_queen: got %b want 10101", q); end
    endtask

    task automatic test_e2e4();
        int lat; logic [2:0] st; logic [4:0] cap, q;
        send(3'd6, 3'd4, 3'd4, 3'd4, 3'd0, lat, st, cap);
        n_tests++; if (lat != 3) begin n_fail++; $display("FAIL e2e4_latency: got %0d want 3", lat); end
        n_tests++; if (st !== 3'd0 || cap !== 5'd0) begin
            n_fail++; $display("FAIL e2e4_rsp: got st=%0d cap=%b want 0 00000", st, cap); end
        rd(3'd4, 3'd4, q);
        n_tests++; if (q !== 5'b00101) begin n_fail++; $display("FAIL e2e4_dst: got %b want 00101", q); end
        rd(3'd6, 3'd4, q);
        n_tests++; if (q !== 5'b0) begin n_fail++; $display("FAIL e2e4_src: got %b want 00000", q); end
        n_tests++; if (side_to_move !== 1'b1 || move_count !== 10'd1) begin
            n_fail++; $display("FAIL e2e4_side_cnt: got s=%b c=%0d want 1 1", side_to_move, move_count); end
        @(posedge clk); #1;
        n_tests++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL rsp_pulse: got %b want 0", rsp_valid); end
    endtask

    task automatic test_wrong_side();
        int lat; logic [2:0] st; logic [4:0] cap, q;
        send(3'd6, 3'd3, 3'd5, 3'd3, 3'd0, lat, st, cap);
        n_tests++; if (st !== 3'd2 || cap !== 5'd0 || lat != 3) begin
            n_fail++; $display("FAIL wrong_side: got st=%0d cap=%b lat=%0d want 2 00000 3", st, cap, lat); end
        rd(3'd6, 3'd3, q);
        n_tests++; if (q !== 5'b00101) begin n_fail++; $display("FAIL wrong_side_board: got %b want 00101", q); end
        n_tests++; if (side_to_move !== 1'b1 || move_count !== 10'd1) begin
            n_fail++; $display("FAIL wrong_side_cnt: got s=%b c=%0d want 1 1", side_to_move, move_count); end
    endtask

    task automatic test_rejects();
        int lat; logic [2:0] st; logic [4:0] cap, q;
        logic [2:0] v [3][5] = '{'{3'd1, 3'd4, 3'd1, 3'd4, 3'd5},
                                 '{3'd2, 3'd0, 3'd3, 3'd0, 3'd1},
                                 '{3'd0, 3'd0, 3'd1, 3'd0, 3'd3}};
        for (int i = 0; i < 3; i++) begin
            send(v[i][0], v[i][1], v[i][2], v[i][3], 3'd0, lat, st, cap);
            n_tests++; if (st !== v[i][4] || cap !== 5'd0) begin
                n_fail++; $display("FAIL reject_%0d: got st=%0d cap=%b want %0d 00000", i, st, cap, v[i][4]); end
        end
        rd(3'd1, 3'd0, q);
        n_tests++; if (q !== 5'b00111 || move_count !== 10'd1) begin
            n_fail++; $display("FAIL reject_board: got sq=%b c=%0d want 00111 1", q, move_count); end
    endtask

    task automatic test_promotion();
        int lat; logic [2:0] st; logic [4:0] cap, q;
        send(3'd1, 3'd7, 3'd2, 3'd7, 3'd0, lat, st, cap);
        n_tests++; if (st !== 3'd0) begin n_fail++; $display("FAIL black_move: got st=%0d want 0", st); end
        send(3'd6, 3'd0, 3'd1, 3'd0, 3'd0, lat, st, cap);
        n_tests++; if (st !== 3'd0 || cap !== 5'b00111) begin
            n_fail++; $display("FAIL pawn_capture: got st=%0d cap=%b want 0 00111", st, cap); end
        rd(3'd1, 3'd0, q);
        n_tests++; if (q !== 5'b00101) begin n_fail++; $display("FAIL no_early_promo: got %b want 00101", q); end
        send(3'd2, 3'd7, 3'd3, 3'd7, 3'd0, lat, st, cap);
        send(3'd1, 3'd0, 3'd0, 3'd1, 3'd0, lat, st, cap);
        n_tests++; if (st !== 3'd0 || cap !== 5'b01011) begin
            n_fail++; $display("FAIL promo_rsp: got st=%0d cap=%b want 0 01011", st, cap); end
        rd(3'd0, 3'd1, q);
        n_tests++; if (q !== 5'b10101) begin n_fail++; $display("FAIL promo_sq: got %b want 10101", q); end
        n_tests++; if (move_count !== 10'd5 || side_to_move !== 1'b1) begin
            n_fail++; $display("FAIL promo_cnt: got c=%0d s=%b want 5 1", move_count, side_to_move); end
    endtask

    task automatic test_init_abort();
        int pulses; logic [4:0] q;
        logic [2:0] rr [5] = '{3'd1, 3'd2, 3'd0, 3'd1, 3'd6};
        logic [2:0] cc [5] = '{3'd1, 3'd1, 3'd1, 3'd0, 3'd0};
        @(negedge clk);
        mv_from_r = 3'd1; mv_from_c = 3'd1; mv_to_r = 3'd2; mv_to_c = 3'd1; mv_valid = 1'b1;
        @(posedge clk); #1; mv_valid = 1'b0;
        @(posedge clk); #1; init = 1'b1;
        n_tests++; if (mv_ready !== 1'b0) begin n_fail++; $display("FAIL ready_in_init: got %b want 0", mv_ready); end
        @(posedge clk); #1; init = 1'b0;
        pulses = 0;
        repeat (6) begin
            if (rsp_valid === 1'b1) pulses++;
            @(posedge clk); #1;
        end
        n_tests++; if (pulses != 0) begin n_fail++; $display("FAIL init_abort_rsp: got %0d pulses want 0", pulses); end
        for (int i = 0; i < 5; i++) begin
            rd(rr[i], cc[i], q);
            n_tests++; if (q !== exp_start(int'(rr[i]), int'(cc[i]), 8)) begin
                n_fail++; $display("FAIL init_sq[%0d][%0d]: got %b want %b", rr[i], cc[i], q, exp_start(int'(rr[i]), int'(cc[i]), 8)); end
        end
        n_tests++; if (move_count !== 10'd0 || side_to_move !== 1'b0) begin
            n_fail++; $display("FAIL init_cnt: got c=%0d s=%b want 0 0", move_count, side_to_move); end
    endtask

    task automatic test_init_with_valid();
        int pulses; logic [4:0] q;
        @(negedge clk);
        mv_from_r = 3'd6; mv_from_c = 3'd4; mv_to_r = 3'd4; mv_to_c = 3'd4; mv_valid = 1'b1; init = 1'b1;
        #1;
        n_tests++; if (mv_ready !== 1'b0) begin n_fail++; $display("FAIL init_valid_ready: got %b want 0", mv_ready); end
        @(posedge clk); #1; mv_valid = 1'b0; init = 1'b0;
        pulses = 0;
        repeat (6) begin
            if (rsp_valid === 1'b1) pulses++;
            @(posedge clk); #1;
        end
        rd(3'd6, 3'd4, q);
        n_tests++; if (pulses != 0 || q !== 5'b00101 || move_count !== 10'd0) begin
            n_fail++; $display("FAIL init_valid_drop: got p=%0d sq=%b c=%0d want 0 00101 0", pulses, q, move_count); end
    endtask

    task automatic test_big_board();
        int lat; logic [2:0] st;
        logic [3:0] rr [8] = '{4'd9, 4'd9, 4'd0, 4'd8, 4'd1, 4'd4, 4'd2, 4'd12};
        logic [2:0] cc [8] = '{3'd0, 3'd5, 3'd4, 3'd2, 3'd5, 3'd2, 3'd7, 3'd0};
        logic [4:0] ee [8] = '{5'b10001, 5'b01101, 5'b11011, 5'b00101, 5'b00111, 5'b0, 5'b0, 5'b0};
        logic [3:0] mf [4] = '{4'd8, 4'd1, 4'd7, 4'd2};
        logic [1:0] ec [4] = '{2'd1, 2'd2, 2'd3, 2'd3};
        for (int i = 0; i < 8; i++) begin
            b_rd_r = rr[i]; b_rd_c = cc[i]; #1;
            n_tests++; if (b_rd_sq !== ee[i]) begin
                n_fail++; $display("FAIL big_rd[%0d][%0d]: got %b want %b", rr[i], cc[i], b_rd_sq, ee[i]); end
        end
        send_b(4'd12, 3'd0, 4'd7, 3'd0, lat, st);
        n_tests++; if (st !== 3'd4 || lat != 3) begin
            n_fail++; $display("FAIL big_range: got st=%0d lat=%0d want 4 3", st, lat); end
        for (int i = 0; i < 4; i++) begin
            send_b(mf[i], 3'd0, mf[i] + ((mf[i] > 4'd4) ? 4'hF : 4'd1), 3'd0, lat, st);
            n_tests++; if (st !== 3'd0 || b_count !== ec[i]) begin
                n_fail++; $display("FAIL big_sat_%0d: got st=%0d c=%0d want 0 %0d", i, st, b_count, ec[i]); end
        end
    endtask

    initial begin
        reset = 1'b1; init = 1'b0; mv_valid = 1'b0; mv_promo = 3'd0;
        mv_from_r = 3'd0; mv_from_c = 3'd0; mv_to_r = 3'd0; mv_to_c = 3'd0; rd_r = 3'd0; rd_c = 3'd0;
        b_init = 1'b0; b_valid = 1'b0; b_from_r = 4'd0; b_from_c = 3'd0; b_to_r = 4'd0; b_to_c = 3'd0;
        b_promo = 3'd0; b_rd_r = 4'd0; b_rd_c = 3'd0;
        test_reset();
        test_e2e4();
        test_wrong_side();
        test_rejects();
        test_promotion();
        test_init_abort();
        test_init_with_valid();
        test_big_board();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
